// File: rtl/knight_motion_ctrl.sv
// Player sprite motion sequencer: per-frame IDLE/RUN/JUMP/FALL/ATTACK FSM driven
// by keycode, with position/velocity integration on each detected VGA frame.
module knight_motion_ctrl #(
  parameter int X_START       = 320,
  parameter int X_MIN         = 0,
  parameter int X_MAX         = 639,
  parameter int Y_MIN         = 16,
  parameter int Y_GROUND      = 400,
  parameter int SIZE          = 16,
  parameter int X_STEP        = 2,
  parameter int JUMP_V        = 12,
  parameter int GRAVITY       = 1,
  parameter int V_MAX         = 15,
  parameter int ATTACK_FRAMES = 8
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_vs,
  input  logic [7:0] keycode,
  output logic [9:0] PlayerX,
  output logic [9:0] PlayerY,
  output logic [9:0] PlayerS,
  output logic       facing,
  output logic       attack_active,
  output logic [2:0] state_o,
  output logic       frame_tick
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN    = 3'd1,
    S_JUMP   = 3'd2,
    S_FALL   = 3'd3,
    S_ATTACK = 3'd4
  } state_e;

  localparam int ATK_W = $clog2(ATTACK_FRAMES + 1);

  localparam logic [7:0] KEY_LEFT  = 8'h04;
  localparam logic [7:0] KEY_RIGHT = 8'h07;
  localparam logic [7:0] KEY_JUMP  = 8'h2C;
  localparam logic [7:0] KEY_ATK   = 8'h0D;

  localparam logic [9:0] X_RST  = 10'(X_START);
  localparam logic [9:0] X_LO   = 10'(X_MIN);
  localparam logic [9:0] X_HI   = 10'(X_MAX - SIZE + 1);
  localparam logic [9:0] STEP   = 10'(X_STEP);
  localparam logic [9:0] Y_TOP  = 10'(Y_MIN);
  localparam logic [9:0] Y_GND  = 10'(Y_GROUND);
  localparam logic [9:0] SPR_SZ = 10'(SIZE);

  localparam logic signed [10:0] Y_TOP_S = 11'(Y_MIN);
  localparam logic signed [10:0] Y_GND_S = 11'(Y_GROUND);

  localparam logic signed [5:0] VY_JUMP = 6'(-JUMP_V);
  localparam logic signed [5:0] VY_GRAV = 6'(GRAVITY);
  localparam logic signed [5:0] VY_MAX  = 6'(V_MAX);

  localparam logic [ATK_W-1:0] ATK_INIT = ATK_W'(ATTACK_FRAMES - 1);

  // Frame detect: two-flop synchroniser, registered falling-edge pulse
  logic vs_s1_q, vs_s2_q, vs_prev_q, tick_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      vs_s1_q   <= 1'b1;
      vs_s2_q   <= 1'b1;
      vs_prev_q <= 1'b1;
      tick_q    <= 1'b0;
    end else begin
      vs_s1_q   <= frame_vs;
      vs_s2_q   <= vs_s1_q;
      vs_prev_q <= vs_s2_q;
      tick_q    <= vs_prev_q & ~vs_s2_q;
    end
  end

  state_e                state_q, state_d;
  logic [9:0]            x_q, x_d;
  logic [9:0]            y_q, y_d;
  logic signed [5:0]     vy_q, vy_d;
  logic                  facing_q, facing_d;
  logic                  atk_q, atk_d;
  logic [ATK_W-1:0]      atk_cnt_q, atk_cnt_d;
  logic [7:0]            prev_key_q, prev_key_d;

  logic                  key_left, key_right, key_move;
  logic                  jump_edge, atk_edge;
  logic signed [10:0]    vy_ext, y_sum;
  logic signed [5:0]     vy_grav;

  always_comb begin
    key_left  = (keycode == KEY_LEFT);
    key_right = (keycode == KEY_RIGHT);
    key_move  = key_left | key_right;
    jump_edge = (keycode == KEY_JUMP) && (prev_key_q != KEY_JUMP);
    atk_edge  = (keycode == KEY_ATK)  && (prev_key_q != KEY_ATK);
    vy_ext    = {{5{vy_q[5]}}, vy_q};
    y_sum     = $signed({1'b0, y_q}) + vy_ext;
    vy_grav   = vy_q + VY_GRAV;
  end

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    vy_d       = vy_q;
    facing_d   = facing_q;
    atk_d      = atk_q;
    atk_cnt_d  = atk_cnt_q;
    prev_key_d = prev_key_q;

    if (tick_q) begin
      prev_key_d = keycode;

      if (state_q inside {S_IDLE, S_RUN, S_JUMP, S_FALL}) begin
        if (key_left) begin
          x_d      = (x_q < X_LO + STEP) ? X_LO : x_q - STEP;
          facing_d = 1'b0;
        end else if (key_right) begin
          x_d      = (x_q > X_HI - STEP) ? X_HI : x_q + STEP;
          facing_d = 1'b1;
        end
      end

      case (state_q)
        S_IDLE, S_RUN: begin
          if (jump_edge) begin
            state_d = S_JUMP;
            vy_d    = VY_JUMP;
          end else if (atk_edge) begin
            state_d   = S_ATTACK;
            atk_cnt_d = ATK_INIT;
            atk_d     = 1'b1;
          end else begin
            state_d = key_move ? S_RUN : S_IDLE;
          end
        end

        S_JUMP: begin
          if (y_sum < Y_TOP_S) begin
            y_d     = Y_TOP;
            vy_d    = '0;
            state_d = S_FALL;
          end else begin
            y_d  = y_sum[9:0];
            vy_d = vy_grav;
            if (!vy_grav[5]) state_d = S_FALL;
          end
        end

        S_FALL: begin
          if (y_sum >= Y_GND_S) begin
            y_d     = Y_GND;
            vy_d    = '0;
            state_d = key_move ? S_RUN : S_IDLE;
          end else begin
            y_d  = y_sum[9:0];
            vy_d = (vy_grav > VY_MAX) ? VY_MAX : vy_grav;
          end
        end

        S_ATTACK: begin
          if (atk_cnt_q != '0) begin
            atk_cnt_d = atk_cnt_q - 1'b1;
          end else begin
            state_d = S_IDLE;
            atk_d   = 1'b0;
          end
        end

        default: begin
          state_d = S_IDLE;
          atk_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      x_q        <= X_RST;
      y_q        <= Y_GND;
      vy_q       <= '0;
      facing_q   <= 1'b1;
      atk_q      <= 1'b0;
      atk_cnt_q  <= '0;
      prev_key_q <= '0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      vy_q       <= vy_d;
      facing_q   <= facing_d;
      atk_q      <= atk_d;
      atk_cnt_q  <= atk_cnt_d;
      prev_key_q <= prev_key_d;
    end
  end

  assign PlayerX       = x_q;
  assign PlayerY       = y_q;
  assign PlayerS       = SPR_SZ;
  assign facing        = facing_q;
  assign attack_active = atk_q;
  assign state_o       = state_q;
  assign frame_tick    = tick_q;

endmodule

// File: tb/tb_knight_motion_ctrl.sv
// Directed bench for knight_motion_ctrl: frame-by-frame key stimulus with
// hand-computed position/state expectations.
module tb_knight_motion_ctrl;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       frame_vs;
  logic [7:0] keycode;
  logic [9:0] PlayerX, PlayerY, PlayerS;
  logic       facing, attack_active, frame_tick;
  logic [2:0] state_o;

  int n_total = 0;
  int n_bad   = 0;

  always #5 Clk = ~Clk;

  knight_motion_ctrl dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .frame_vs      (frame_vs),
    .keycode       (keycode),
    .PlayerX       (PlayerX),
    .PlayerY       (PlayerY),
    .PlayerS       (PlayerS),
    .facing        (facing),
    .attack_active (attack_active),
    .state_o       (state_o),
    .frame_tick    (frame_tick)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One VS fall with keycode held; returns once the tick's update is visible
  task automatic frame(input logic [7:0] key);
    int lat;
    bit seen;
    @(negedge Clk);
    keycode  = key;
    frame_vs = 1'b0;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 8) begin
      @(posedge Clk);
      #1;
      lat++;
      seen = frame_tick;
    end
    check("tick_seen", int'(seen), 1);
    if (seen) check("tick_latency", lat, 3);
    @(posedge Clk);
    #1;
    check("tick_width", int'(frame_tick), 0);
    @(negedge Clk);
    frame_vs = 1'b1;
    repeat (3) @(posedge Clk);
  endtask

  task automatic frames(input int n, input logic [7:0] key);
    for (int i = 0; i < n; i++) frame(key);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    Reset    = 1'b1;
    frame_vs = 1'b1;
    keycode  = 8'h00;

    // 1: reset with VS toggling
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      frame_vs = ~frame_vs;
      @(posedge Clk);
      #1;
      check("rst_no_tick", int'(frame_tick), 0);
    end
    @(negedge Clk);
    frame_vs = 1'b1;
    Reset    = 1'b0;
    repeat (4) @(posedge Clk);
    #1;
    check("rst_x", PlayerX, 320);
    check("rst_y", PlayerY, 400);
    check("rst_state", state_o, 0);
    check("rst_facing", facing, 1);
    check("rst_attack", attack_active, 0);
    check("size", PlayerS, 16);

    // 2: run right then clamp left
    frames(10, 8'h07);
    check("run_r_x", PlayerX, 340);
    check("run_r_state", state_o, 1);
    check("run_r_facing", facing, 1);
    frames(200, 8'h04);
    check("run_l_clamp_x", PlayerX, 0);
    check("run_l_facing", facing, 0);
    check("run_l_state", state_o, 1);
    frame(8'h00);
    check("stop_state", state_o, 0);

    // 3: single jump, apex at 400-78, lands 25 ticks after takeoff
    frame(8'h2C);
    check("jump_state", state_o, 2);
    check("jump_y0", PlayerY, 400);
    frame(8'h00);
    check("jump_y1", PlayerY, 388);
    frames(11, 8'h00);
    check("apex_y", PlayerY, 322);
    check("apex_state", state_o, 3);
    frames(12, 8'h00);
    check("fall_y", PlayerY, 388);
    check("fall_state", state_o, 3);
    frame(8'h00);
    check("land_y", PlayerY, 400);
    check("land_state", state_o, 0);

    // 4: holding space gives only one jump
    frame(8'h2C);
    check("hold_jump_state", state_o, 2);
    frames(25, 8'h2C);
    check("hold_land_y", PlayerY, 400);
    check("hold_land_state", state_o, 0);
    frames(5, 8'h2C);
    check("hold_no_rejump", state_o, 0);
    check("hold_no_rejump_y", PlayerY, 400);
    frame(8'h00);
    frame(8'h2C);
    check("repress_jump", state_o, 2);
    frames(25, 8'h00);
    check("repress_land", state_o, 0);

    // 5: attack freezes X and facing for 8 ticks
    frame(8'h0D);
    check("atk_state", state_o, 4);
    check("atk_active", attack_active, 1);
    for (int i = 0; i < 7; i++) begin
      frame(8'h07);
      check("atk_hold_active", attack_active, 1);
      check("atk_hold_x", PlayerX, 0);
      check("atk_hold_state", state_o, 4);
    end
    frame(8'h07);
    check("atk_end_state", state_o, 0);
    check("atk_end_active", attack_active, 0);
    check("atk_end_x", PlayerX, 0);
    check("atk_end_facing", facing, 0);
    frame(8'h07);
    check("post_atk_run", state_o, 1);
    check("post_atk_x", PlayerX, 2);
    frame(8'h00);

    // J right after takeoff is ignored while airborne
    frame(8'h2C);
    frame(8'h0D);
    check("air_j_state", state_o, 2);
    check("air_j_active", attack_active, 0);
    check("air_j_y", PlayerY, 388);
    frames(24, 8'h00);
    check("air_j_land", state_o, 0);
    check("air_j_land_y", PlayerY, 400);

    // 6: reset mid-jump
    frame(8'h2C);
    frames(5, 8'h00);
    check("mid_jump_y", PlayerY, 350);
    check("mid_jump_state", state_o, 2);
    @(negedge Clk);
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    check("midrst_y", PlayerY, 400);
    check("midrst_x", PlayerX, 320);
    check("midrst_state", state_o, 0);
    check("midrst_attack", attack_active, 0);
    check("midrst_tick", int'(frame_tick), 0);
    @(negedge Clk);
    Reset = 1'b0;
    frame(8'h2C);
    check("post_rst_jump", state_o, 2);
    frame(8'h00);
    check("post_rst_y1", PlayerY, 388);
    frames(24, 8'h00);
    check("post_rst_land", PlayerY, 400);

    // right-edge clamp at X_MAX-SIZE+1
    frames(160, 8'h07);
    check("run_r_clamp_x", PlayerX, 624);
    check("run_r_clamp_facing", facing, 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
